mem_arbiter: RTL and testbench

Shares the single external memory port between the CPU control unit (`ctrl`) and a host/debug loader port. Requests are granted round-robin, and each granted request runs as one handshake transaction on the memory side. A completion pulse is returned to the owning requester. A timeout guard keeps a missing `mem_ack` from hanging either requester. The block sits between `ctrl`/address registers on one side and the memory interface on the other.

---
 rtl/controlpack.sv | 34 +++
 rtl/mem_arbiter.sv | 163 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/controlpack.sv
// Shared control types for the CPU control unit and the memory-side arbiter.
package controlpack;

    typedef enum logic [1:0] {
        MEM_NOP   = 2'd0,
        MEM_READ  = 2'd1,
        MEM_WRITE = 2'd2
    } mem_ctrl_op_e;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_BUSY = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_CPU  = 1'b0,
        OWN_HOST = 1'b1
    } arb_owner_e;

    // Round-robin pick: on a tie the requester that did not win last time is served.
    function automatic arb_owner_e rr_pick(input logic cpu_pend,
                                           input logic host_pend,
                                           input arb_owner_e last);
        if (cpu_pend && host_pend) begin
            return (last == OWN_CPU) ? OWN_HOST : OWN_CPU;
        end else if (host_pend) begin
            return OWN_HOST;
        end else begin
            return OWN_CPU;
        end
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between ctrl and the host loader,
// with a per-transaction timeout guard against a missing mem_ack.
//   state    | meaning
//   ARB_IDLE | waiting for a pending request, grant on the next edge
//   ARB_BUSY | mem_req held until mem_ack or timeout
//   ARB_RESP | owner's done pulses, requests ignored
module mem_arbiter
    import controlpack::*;
#(
    parameter int DATA_BUS_WIDTH = 8,
    parameter int ADDR_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                      clock,
    input  logic                      reset,
    input  mem_ctrl_op_e              cpu_op,
    input  logic [ADDR_WIDTH-1:0]     cpu_addr,
    input  logic [DATA_BUS_WIDTH-1:0] cpu_wdata,
    output logic [DATA_BUS_WIDTH-1:0] cpu_rdata,
    output logic                      cpu_done,
    input  logic                      host_req,
    input  logic                      host_we,
    input  logic [ADDR_WIDTH-1:0]     host_addr,
    input  logic [DATA_BUS_WIDTH-1:0] host_wdata,
    output logic [DATA_BUS_WIDTH-1:0] host_rdata,
    output logic                      host_done,
    output logic                      mem_req,
    output logic                      mem_we,
    output logic [ADDR_WIDTH-1:0]     mem_addr,
    output logic [DATA_BUS_WIDTH-1:0] mem_wdata,
    input  logic [DATA_BUS_WIDTH-1:0] mem_rdata,
    input  logic                      mem_ack,
    output logic                      timeout_err,
    input  logic                      err_clear
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES);

    arb_state_e                r_state;
    arb_state_e                w_state_next;
    arb_owner_e                r_owner;
    arb_owner_e                r_last_grant;
    arb_owner_e                w_grant_owner;
    logic [CNT_W-1:0]          r_cnt;
    logic [CNT_W-1:0]          w_cnt_inc;
    logic                      r_mem_req;
    logic                      r_mem_we;
    logic [ADDR_WIDTH-1:0]     r_mem_addr;
    logic [DATA_BUS_WIDTH-1:0] r_mem_wdata;
    logic [DATA_BUS_WIDTH-1:0] r_cpu_rdata;
    logic [DATA_BUS_WIDTH-1:0] r_host_rdata;
    logic                      r_cpu_done;
    logic                      r_host_done;
    logic                      r_timeout_err;

    logic                      w_cpu_pend;
    logic                      w_host_pend;
    logic                      w_grant;
    logic                      w_timeout;
    logic                      w_finish;
    logic [DATA_BUS_WIDTH-1:0] w_rd_value;

    assign w_cpu_pend    = (cpu_op != MEM_NOP);
    assign w_host_pend   = host_req;
    assign w_grant_owner = rr_pick(w_cpu_pend, w_host_pend, r_last_grant);
    assign w_grant       = (r_state == ARB_IDLE) && (w_cpu_pend || w_host_pend);
    assign w_cnt_inc     = r_cnt + CNT_W'(1);
    // Ack in the last allowed cycle still counts as a normal completion.
    assign w_timeout     = (r_state == ARB_BUSY) && !mem_ack && (w_cnt_inc == CNT_LAST);
    assign w_finish      = (r_state == ARB_BUSY) && (mem_ack || w_timeout);
    assign w_rd_value    = mem_ack ? mem_rdata : '1;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ARB_IDLE: if (w_grant)  w_state_next = ARB_BUSY;
            ARB_BUSY: if (w_finish) w_state_next = ARB_RESP;
            ARB_RESP: w_state_next = ARB_IDLE;
            default:  w_state_next = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state       <= ARB_IDLE;
            r_owner       <= OWN_CPU;
            r_last_grant  <= OWN_HOST;
            r_cnt         <= '0;
            r_mem_req     <= 1'b0;
            r_mem_we      <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_wdata   <= '0;
            r_cpu_rdata   <= '0;
            r_host_rdata  <= '0;
            r_cpu_done    <= 1'b0;
            r_host_done   <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_cpu_done  <= 1'b0;
            r_host_done <= 1'b0;

            if (w_timeout) begin
                r_timeout_err <= 1'b1;
            end else if (err_clear) begin
                r_timeout_err <= 1'b0;
            end

            case (r_state)
                ARB_IDLE: begin
                    if (w_grant) begin
                        r_owner      <= w_grant_owner;
                        r_last_grant <= w_grant_owner;
                        r_cnt        <= '0;
                        r_mem_req    <= 1'b1;
                        if (w_grant_owner == OWN_CPU) begin
                            r_mem_we    <= (cpu_op == MEM_WRITE);
                            r_mem_addr  <= cpu_addr;
                            r_mem_wdata <= cpu_wdata;
                        end else begin
                            r_mem_we    <= host_we;
                            r_mem_addr  <= host_addr;
                            r_mem_wdata <= host_wdata;
                        end
                    end
                end
                ARB_BUSY: begin
                    if (w_finish) begin
                        r_mem_req <= 1'b0;
                        if (r_owner == OWN_CPU) begin
                            r_cpu_done <= 1'b1;
                        end else begin
                            r_host_done <= 1'b1;
                        end
                        if (!r_mem_we) begin
                            if (r_owner == OWN_CPU) begin
                                r_cpu_rdata <= w_rd_value;
                            end else begin
                                r_host_rdata <= w_rd_value;
                            end
                        end
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                ARB_RESP: r_mem_req <= 1'b0;
                default:  r_mem_req <= 1'b0;
            endcase
        end
    end

    assign cpu_rdata   = r_cpu_rdata;
    assign cpu_done    = r_cpu_done;
    assign host_rdata  = r_host_rdata;
    assign host_done   = r_host_done;
    assign mem_req     = r_mem_req;
    assign mem_we      = r_mem_we;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;
    assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios then random transactions, each checked
// against a transaction-level model of grants, read results and the error flag.
module tb_mem_arbiter;
    import controlpack::*;

    localparam int DW = 8;
    localparam int AW = 8;
    localparam int TO = 15;

    logic          clock;
    logic          reset;
    mem_ctrl_op_e  cpu_op;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_done;
    logic          host_req;
    logic          host_we;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata;
    logic [DW-1:0] host_rdata;
    logic          host_done;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;
    logic          timeout_err;
    logic          err_clear;

    mem_arbiter #(
        .DATA_BUS_WIDTH(DW),
        .ADDR_WIDTH    (AW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .cpu_op     (cpu_op),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_done   (cpu_done),
        .host_req   (host_req),
        .host_we    (host_we),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_rdata (host_rdata),
        .host_done  (host_done),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .timeout_err(timeout_err),
        .err_clear  (err_clear)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: who won last, each requester's last read result, sticky error.
    bit            m_last_host;
    logic [DW-1:0] m_cpu_rdata;
    logic [DW-1:0] m_host_rdata;
    bit            m_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge in IDLE with requests already driven. delay = cycle of
    // mem_req in which ack is given (0 = never). ack_val < 0 picks random data.
    task automatic run_txn(input int delay, input bit clr_same, input bit drop_owner, input int ack_val);
        bit            cp, hp, own_host, exp_we, timed;
        logic [AW-1:0] exp_addr;
        logic [DW-1:0] exp_wdata, ack_data;
        int            c, guard, exp_len;
        cp = (cpu_op != MEM_NOP);
        hp = host_req;
        own_host = (cp && hp) ? !m_last_host : hp;
        if (own_host) begin
            exp_we = host_we; exp_addr = host_addr; exp_wdata = host_wdata;
        end else begin
            exp_we = (cpu_op == MEM_WRITE); exp_addr = cpu_addr; exp_wdata = cpu_wdata;
        end
        if (err_clear) m_err = 0;
        m_last_host = own_host;
        timed   = (delay == 0);
        exp_len = timed ? TO : delay;
        c = 0; guard = 0; ack_data = '0;

        @(negedge clock);
        chk("grant_latency", mem_req, 1);
        err_clear = 1'b0;
        while (mem_req === 1'b1 && guard < 3 * TO) begin
            c++; guard++;
            chk("mem_addr", mem_addr, exp_addr);
            chk("mem_we", mem_we, exp_we);
            chk("mem_wdata", mem_wdata, exp_wdata);
            chk("done_in_busy", {cpu_done, host_done}, 0);
            if (c == 1) chk("err_at_grant", timeout_err, m_err);
            if (own_host) begin
                host_addr = AW'($urandom); host_wdata = DW'($urandom);
            end else begin
                cpu_addr = AW'($urandom); cpu_wdata = DW'($urandom);
            end
            mem_rdata = (ack_val < 0) ? DW'($urandom) : ack_val[DW-1:0];
            if (c == delay) ack_data = mem_rdata;
            mem_ack   = (c == delay);
            err_clear = timed && clr_same && (c == TO);
            @(negedge clock);
        end
        chk("mem_req_drop", mem_req, 0);
        chk("mem_req_cycles", c, exp_len);
        if (timed) m_err = 1;
        if (!exp_we) begin
            if (own_host) m_host_rdata = timed ? '1 : ack_data;
            else          m_cpu_rdata  = timed ? '1 : ack_data;
        end
        chk("cpu_done", cpu_done, !own_host);
        chk("host_done", host_done, own_host);
        chk("cpu_rdata", cpu_rdata, m_cpu_rdata);
        chk("host_rdata", host_rdata, m_host_rdata);
        chk("timeout_err", timeout_err, m_err);
        // Stray ack in RESP must be ignored.
        mem_ack   = 1'($urandom_range(0, 1));
        mem_rdata = DW'($urandom);
        err_clear = 1'b0;

        @(negedge clock);
        chk("idle_no_req", mem_req, 0);
        chk("done_one_cycle", {cpu_done, host_done}, 0);
        chk("cpu_rdata_hold", cpu_rdata, m_cpu_rdata);
        chk("host_rdata_hold", host_rdata, m_host_rdata);
        mem_ack   = 1'($urandom_range(0, 1));
        mem_rdata = DW'($urandom);
        if (drop_owner) begin
            if (own_host) host_req = 1'b0;
            else          cpu_op   = MEM_NOP;
        end
    endtask

    initial begin
        int dly;
        reset = 1'b0;
        cpu_op = MEM_NOP; cpu_addr = '0; cpu_wdata = '0;
        host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
        mem_rdata = '0; mem_ack = 1'b0; err_clear = 1'b0;
        m_last_host = 1; m_cpu_rdata = '0; m_host_rdata = '0; m_err = 0;

        repeat (2) @(negedge clock);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_dones", {cpu_done, host_done}, 0);
        chk("rst_rdata", {cpu_rdata, host_rdata}, 0);
        chk("rst_err", timeout_err, 0);
        reset = 1'b1;
        @(negedge clock);

        // CPU read of 0x12, ack in the second mem_req cycle with 0xA5.
        cpu_op = MEM_READ; cpu_addr = 8'h12;
        run_txn(2, 0, 1, 'hA5);
        chk("t1_cpu_rdata", cpu_rdata, 8'hA5);

        // Host write 0x3C to 0x40.
        host_req = 1'b1; host_we = 1'b1; host_addr = 8'h40; host_wdata = 8'h3C;
        run_txn(3, 0, 1, -1);
        chk("t2_cpu_rdata_kept", cpu_rdata, 8'hA5);

        // Host read with no ack: timeout after TO cycles.
        host_req = 1'b1; host_we = 1'b0; host_addr = 8'h55;
        run_txn(0, 0, 1, -1);
        chk("t3_host_rdata_ones", host_rdata, 8'hFF);
        chk("t3_err_set", timeout_err, 1);
        err_clear = 1'b1;
        @(negedge clock);
        err_clear = 1'b0;
        m_err = 0;
        chk("t3_err_cleared", timeout_err, 0);

        // Both requesting continuously: grants alternate CPU, HOST, CPU, HOST.
        for (int i = 0; i < 4; i++) begin
            cpu_op = MEM_READ; cpu_addr = 8'h10 + 8'(i);
            host_req = 1'b1; host_we = 1'b0; host_addr = 8'h20 + 8'(i);
            run_txn(1 + (i % 3), 0, 0, -1);
            chk("tie_sequence", mem_addr[7:4], (i % 2 == 0) ? 4'h1 : 4'h2);
        end

        // Timeout with err_clear in the same cycle: set wins.
        cpu_op = MEM_NOP;
        host_req = 1'b1; host_we = 1'b0; host_addr = 8'h66;
        run_txn(0, 1, 1, -1);
        chk("set_wins_clear", timeout_err, 1);

        // Random traffic.
        for (int n = 0; n < 150; n++) begin
            if (cpu_op == MEM_NOP && $urandom_range(0, 1) == 1) begin
                cpu_op = ($urandom_range(0, 1) == 1) ? MEM_READ : MEM_WRITE;
                cpu_addr = AW'($urandom); cpu_wdata = DW'($urandom);
            end
            if (!host_req && $urandom_range(0, 1) == 1) begin
                host_req = 1'b1; host_we = 1'($urandom_range(0, 1));
                host_addr = AW'($urandom); host_wdata = DW'($urandom);
            end
            if (cpu_op == MEM_NOP && !host_req) begin
                cpu_op = MEM_READ; cpu_addr = AW'($urandom);
            end
            err_clear = ($urandom_range(0, 4) == 0);
            dly = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 5);
            run_txn(dly, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1);
        end

        // Reset in the middle of a CPU transaction.
        cpu_op = MEM_READ; cpu_addr = 8'h77; host_req = 1'b0; mem_ack = 1'b0; err_clear = 1'b0;
        @(negedge clock);
        chk("pre_reset_busy", mem_req, 1);
        #2 reset = 1'b0;
        #1;
        chk("async_mem_req", mem_req, 0);
        chk("async_mem_we", mem_we, 0);
        chk("async_mem_addr", mem_addr, 0);
        chk("async_mem_wdata", mem_wdata, 0);
        chk("async_rdata", {cpu_rdata, host_rdata}, 0);
        chk("async_err", timeout_err, 0);
        host_req = 1'b1; host_we = 1'b0; host_addr = 8'h88; mem_ack = 1'b0;
        repeat (3) begin
            @(negedge clock);
            chk("reset_no_done", {cpu_done, host_done}, 0);
        end
        reset = 1'b1;
        m_last_host = 1; m_cpu_rdata = '0; m_host_rdata = '0; m_err = 0;
        run_txn(2, 0, 1, -1);
        chk("rr_after_reset", mem_addr, 8'h77);
        run_txn(1, 0, 1, -1);
        chk("rr_after_reset_host", mem_addr, 8'h88);

        repeat (2) @(negedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
